// File: rtl/bcd_adjust_pkg.sv
// bcd_adjust_pkg: state encodings and nibble-adjust helper shared by the BCD back end.
//   BCD_IDLE/BCD_LO/BCD_HI/BCD_DONE : 2-bit sequencer states
//   fix_addend(fix, sub)            : 4-bit addend for one nibble correction step
package bcd_adjust_pkg;

    typedef enum logic [1:0] {
        BCD_IDLE = 2'd0,
        BCD_LO   = 2'd1,
        BCD_HI   = 2'd2,
        BCD_DONE = 2'd3
    } bcd_state_t;

    localparam logic [3:0] BCD_ADJ_ADD = 4'h6;
    // Subtracting 6 from a nibble is the same as adding 10 modulo 16.
    localparam logic [3:0] BCD_ADJ_SUB = 4'hA;

    function automatic logic [3:0] fix_addend(input logic fix, input logic sub);
        return fix ? (sub ? BCD_ADJ_SUB : BCD_ADJ_ADD) : 4'h0;
    endfunction

endpackage

// File: rtl/bcd_nibble_fix.sv
// bcd_nibble_fix: combinational decimal correction of one nibble.
//   i_nibble : nibble to correct
//   i_fix    : apply the +6 (ADC) / -6 (SBC) correction
//   i_sub    : 0 = ADC, 1 = SBC
//   i_ci     : carry into the nibble
//   o_nibble : corrected nibble
//   o_co     : carry out (always 0 for SBC, which never borrows across nibbles)
module bcd_nibble_fix
    import bcd_adjust_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_fix,
    input  logic       i_sub,
    input  logic       i_ci,
    output logic [3:0] o_nibble,
    output logic       o_co
);

    logic [4:0] w_sum;

    assign w_sum    = {1'b0, i_nibble} + {1'b0, fix_addend(i_fix, i_sub)} + {4'b0, i_ci};
    assign o_nibble = w_sum[3:0];
    assign o_co     = ~i_sub & w_sum[4];

endmodule

// File: rtl/bcd_adjust.sv
// bcd_adjust: two-step decimal correction of a binary ADC/SBC result with start/done handshake.
//   clk, rst_n                       : clock, async active-low reset
//   start, abort                     : request (IDLE/DONE only), synchronous flush to IDLE
//   sub, bin_res, c_bin, hcb, dhc,
//   dc, v_bin                        : operation and binary ALU result/flags, captured on accept
//   busy, done                       : busy in LO/HI, one-cycle done pulse
//   res, c_out, n_out, z_out, v_out  : corrected byte and final flags, held until next HI edge
module bcd_adjust
    import bcd_adjust_pkg::*;
#(
    parameter bit CMOS_FLAGS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sub,
    input  logic [7:0] bin_res,
    input  logic       c_bin,
    input  logic       hcb,
    input  logic       dhc,
    input  logic       dc,
    input  logic       v_bin,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [7:0] res,
    output logic       c_out,
    output logic       n_out,
    output logic       z_out,
    output logic       v_out
);

    bcd_state_t r_state;
    bcd_state_t w_next;
    logic [7:0] r_work;
    logic [7:0] r_bin;
    logic       r_sub;
    logic       r_lo_fix;
    logic       r_hi_fix;
    logic       r_c;
    logic       r_v;
    logic       w_accept;
    logic [3:0] w_lo_nib;
    logic       w_lo_co;
    logic [3:0] w_hi_nib;
    logic       w_unused_hi_co;
    logic [7:0] w_final;
    logic [7:0] w_flag_src;

    assign w_accept = start & ~abort & (r_state == BCD_IDLE | r_state == BCD_DONE);
    assign busy     = r_state == BCD_LO | r_state == BCD_HI;
    assign done     = r_state == BCD_DONE;

    always_comb begin
        w_next = r_state;
        if (abort)
            w_next = BCD_IDLE;
        else
            case (r_state)
                BCD_IDLE: w_next = start ? BCD_LO : BCD_IDLE;
                BCD_LO:   w_next = BCD_HI;
                BCD_HI:   w_next = BCD_DONE;
                BCD_DONE: w_next = start ? BCD_LO : BCD_IDLE;
                default:  w_next = BCD_IDLE;
            endcase
    end

    bcd_nibble_fix u_lo (
        .i_nibble (r_work[3:0]),
        .i_fix    (r_lo_fix),
        .i_sub    (r_sub),
        .i_ci     (1'b0),
        .o_nibble (w_lo_nib),
        .o_co     (w_lo_co)
    );

    // The high-nibble instance does double duty: in LO it only absorbs the
    // low-step carry, in HI it applies the high correction.
    bcd_nibble_fix u_hi (
        .i_nibble (r_work[7:4]),
        .i_fix    (r_state == BCD_HI & r_hi_fix),
        .i_sub    (r_sub),
        .i_ci     (r_state == BCD_LO & w_lo_co),
        .o_nibble (w_hi_nib),
        .o_co     (w_unused_hi_co)
    );

    assign w_final    = {w_hi_nib, r_work[3:0]};
    assign w_flag_src = CMOS_FLAGS ? w_final : r_bin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= BCD_IDLE;
            r_work   <= 8'h00;
            r_bin    <= 8'h00;
            r_sub    <= 1'b0;
            r_lo_fix <= 1'b0;
            r_hi_fix <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            res      <= 8'h00;
            c_out    <= 1'b0;
            n_out    <= 1'b0;
            z_out    <= 1'b1;
            v_out    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_work   <= bin_res;
                r_bin    <= bin_res;
                r_sub    <= sub;
                r_v      <= v_bin;
                r_lo_fix <= sub ? hcb : (hcb | dhc);
                r_hi_fix <= sub ? ~c_bin : (c_bin | dc);
                r_c      <= sub ? c_bin : (c_bin | dc);
            end else if (!abort && r_state == BCD_LO) begin
                r_work <= {w_hi_nib, w_lo_nib};
            end else if (!abort && r_state == BCD_HI) begin
                res   <= w_final;
                c_out <= r_c;
                n_out <= w_flag_src[7];
                z_out <= w_flag_src == 8'h00;
                v_out <= r_v;
            end
        end
    end

endmodule
